// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over
// back-to-back windows of GATE_CYCLES clocks and publishes each count with a strobe.
module freq_meter #(
    parameter int GATE_CYCLES = 48_000_000,
    parameter int CNT_W       = 32
) (
    input  logic             clk_48MHZ,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_hz,
    output logic             freq_valid,
    output logic             overflow,
    output logic             gate
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic             ovf_flag_q, ovf_flag_d;
    logic [CNT_W-1:0] freq_hz_q, freq_hz_d;
    logic             freq_valid_q, freq_valid_d;
    logic             overflow_q, overflow_d;
    logic             rise;

    // s1/s2 resolve metastability; s3 is only the edge-detect history.
    assign rise = s2_q & ~s3_q;

    always_comb begin
        state_d      = state_q;
        s1_d         = sig_in;
        s2_d         = s1_q;
        s3_d         = s2_q;
        edge_cnt_d   = edge_cnt_q;
        gate_cnt_d   = gate_cnt_q;
        ovf_flag_d   = ovf_flag_q;
        freq_hz_d    = freq_hz_q;
        freq_valid_d = 1'b0;
        overflow_d   = overflow_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d    = GATE;
                    edge_cnt_d = '0;
                    gate_cnt_d = '0;
                    ovf_flag_d = 1'b0;
                end
            end
            GATE: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                    if (rise) begin
                        if (edge_cnt_q == CNT_MAX) begin
                            ovf_flag_d = 1'b1;
                        end else begin
                            edge_cnt_d = edge_cnt_q + CNT_W'(1);
                        end
                    end
                    if (gate_cnt_q == GATE_LAST) begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                // Published even if en has dropped: the window did complete.
                freq_hz_d    = edge_cnt_q;
                overflow_d   = ovf_flag_q;
                freq_valid_d = 1'b1;
                if (en) begin
                    state_d    = GATE;
                    edge_cnt_d = '0;
                    gate_cnt_d = '0;
                    ovf_flag_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_48MHZ) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            edge_cnt_q   <= '0;
            gate_cnt_q   <= '0;
            ovf_flag_q   <= 1'b0;
            freq_hz_q    <= '0;
            freq_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            edge_cnt_q   <= edge_cnt_d;
            gate_cnt_q   <= gate_cnt_d;
            ovf_flag_q   <= ovf_flag_d;
            freq_hz_q    <= freq_hz_d;
            freq_valid_q <= freq_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign freq_hz    = freq_hz_q;
    assign freq_valid = freq_valid_q;
    assign overflow   = overflow_q;
    assign gate       = (state_q == GATE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (32-bit and 4-bit counters) against a
// window-level model, plus directed literal checks of the measured values.
module tb_freq_meter;

    localparam int G = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sig_in = 1'b0;
    logic [31:0] f32;
    logic        v32, o32, g32;
    logic [3:0]  f4;
    logic        v4, o4, g4;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) dut (
        .clk_48MHZ(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .freq_hz(f32), .freq_valid(v32), .overflow(o32), .gate(g32)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
        .clk_48MHZ(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .freq_hz(f4), .freq_valid(v4), .overflow(o4), .gate(g4)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Signal source: sig_period==0 means hold sig_level, else square wave.
    int   sig_period = 2;
    logic sig_level  = 1'b0;
    int   sig_ph     = 0;
    always @(negedge clk) begin
        if (sig_period == 0) begin
            sig_in = sig_level;
        end else begin
            sig_ph = (sig_ph + 1) % sig_period;
            sig_in = (sig_ph < sig_period / 2);
        end
    end

    // Window-level model: count is unbounded, saturation applied on publish.
    int     cyc = 0;
    bit     model_live = 0;
    int     ph = 0;
    int     pos = 0;
    longint cnt = 0;
    logic   hist[$] = '{1'b0, 1'b0, 1'b0};
    logic   m_rise;
    longint e_f32 = 0;
    longint e_f4 = 0;
    logic   e_v = 1'b0, e_o32 = 1'b0, e_o4 = 1'b0, e_g = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            ph = 0; pos = 0; cnt = 0;
            hist = '{1'b0, 1'b0, 1'b0};
            e_f32 = 0; e_f4 = 0; e_v = 1'b0; e_o32 = 1'b0; e_o4 = 1'b0; e_g = 1'b0;
        end else begin
            m_rise = hist[1] && !hist[2];
            hist.push_front(sig_in);
            void'(hist.pop_back());
            e_v = 1'b0;
            case (ph)
                0: if (en) begin ph = 1; pos = 0; cnt = 0; end
                1: begin
                    if (!en) begin
                        ph = 0;
                    end else begin
                        if (m_rise) cnt++;
                        if (pos == G - 1) ph = 2; else pos++;
                    end
                end
                default: begin
                    e_f32 = (cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : cnt;
                    e_o32 = (cnt > 64'hFFFF_FFFF);
                    e_f4  = (cnt > 15) ? 15 : cnt;
                    e_o4  = (cnt > 15);
                    e_v   = 1'b1;
                    if (en) begin ph = 1; pos = 0; cnt = 0; end
                    else ph = 0;
                end
            endcase
            e_g = (ph == 1);
        end
        model_live = 1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("m_freq32", f32, e_f32);
            check("m_valid32", v32, e_v);
            check("m_ovf32", o32, e_o32);
            check("m_gate32", g32, e_g);
            check("m_freq4", f4, e_f4);
            check("m_valid4", v4, e_v);
            check("m_ovf4", o4, e_o4);
            check("m_gate4", g4, e_g);
        end
    end

    task automatic wait_valid(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (v32) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic expect_valid(input string nm);
        bit ok;
        wait_valid(3 * G, ok);
        check(nm, ok, 1);
    endtask

    // Starts on a cycle where gate is high; returns how many cycles it stays high.
    task automatic gate_len(output int n);
        n = 1;
        for (int i = 0; i < 3 * G; i++) begin
            @(negedge clk);
            if (!g32) break;
            n++;
        end
    endtask

    initial begin
        bit ok;
        int n;
        int t0;

        // Reset with sig_in toggling.
        repeat (3) begin
            @(negedge clk);
            check("rst_freq", f32, 0);
            check("rst_valid", v32, 0);
            check("rst_ovf", o32, 0);
            check("rst_gate", g32, 0);
        end

        // Period 10.
        sig_period = 10;
        rst_n = 1'b1;
        en = 1'b1;
        expect_valid("first_valid");
        t0 = cyc;
        gate_len(n);
        check("gate_len", n, G);
        expect_valid("p10_valid");
        check("valid_gap", cyc - t0, G + 1);
        check("p10_freq", f32, 10);
        check("p10_ovf", o32, 0);
        expect_valid("p10_valid2");
        check("p10_freq2", f32, 10);

        // Period 2, plus saturation on the 4-bit instance.
        sig_period = 2;
        expect_valid("p2_trans");
        expect_valid("p2_valid");
        check("p2_freq32", f32, 50);
        check("p2_ovf32", o32, 0);
        check("p2_freq4", f4, 15);
        check("p2_ovf4", o4, 1);
        sig_period = 10;
        expect_valid("back_trans");
        expect_valid("back_valid");
        check("back_freq32", f32, 10);
        check("back_freq4", f4, 10);
        check("back_ovf4", o4, 0);

        // Constant input levels.
        sig_period = 0;
        sig_level = 1'b0;
        expect_valid("c0_trans");
        expect_valid("c0_valid");
        check("c0_freq", f32, 0);
        en = 1'b0;
        repeat (5) @(negedge clk);
        sig_level = 1'b1;
        repeat (10) @(negedge clk);
        en = 1'b1;
        expect_valid("c1_valid");
        check("c1_idle_rise", f32, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_valid("c1_rst_valid");
        check("c1_sync_rise", f32, 1);
        expect_valid("c1_rst_valid2");
        check("c1_after", f32, 0);

        // Abort a window by dropping en.
        sig_period = 10;
        expect_valid("ab_trans");
        expect_valid("ab_valid");
        check("ab_freq_pre", f32, 10);
        repeat (50) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("ab_gate_off", g32, 0);
        wait_valid(2 * G, ok);
        check("ab_no_valid", ok, 0);
        check("ab_freq_kept", f32, 10);
        en = 1'b1;
        @(negedge clk);
        check("ab_gate_on", g32, 1);
        t0 = cyc;
        gate_len(n);
        check("ab_gate_len", n, G);
        expect_valid("ab_new_valid");
        check("ab_gap", cyc - t0, G + 1);
        check("ab_freq", f32, 10);

        // Reset in the middle of a window.
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_freq", f32, 0);
        check("mr_valid", v32, 0);
        check("mr_ovf", o32, 0);
        check("mr_gate", g32, 0);
        check("mr_freq4", f4, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_gate_rise", g32, 1);
        t0 = cyc;
        expect_valid("mr_valid_after");
        check("mr_gap", cyc - t0, G + 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Gated frequency counter. It counts rising edges of an external, asynchronous signal over a fixed window of GATE_CYCLES cycles of clk_48MHZ. With the default window of 48_000_000 cycles (1 s), the result reads directly in Hz. This block is the measuring counterpart of the 1 Hz divider: it consumes an unknown frequency and reports its value, where the divider generates a known one. It runs back-to-back windows while enabled and publishes each result with a one-cycle strobe.

Parameters:
GATE_CYCLES, 48_000_000, length of the gate window in clk_48MHZ cycles (>= 2); use 100 in simulation.
CNT_W, 32, width of the edge counter and of freq_hz.

Ports:
clk_48MHZ  input  1  system clock, 48 MHz.
rst_n  input  1  reset, synchronous, active-low.
en  input  1  measurement enable (synchronous).
sig_in  input  1  signal under measurement, asynchronous to clk_48MHZ.
freq_hz  output  CNT_W  edge count of the last completed window.
freq_valid  output  1  one-cycle pulse when freq_hz updates.
overflow  output  1  last completed window saturated the counter.
gate  output  1  high while a window is open.

Behaviour:
- Clock and reset: one clock, clk_48MHZ. Reset is synchronous and active-low (rst_n); it is sampled only on the rising edge of clk_48MHZ.
- Reset (rst_n=0 at a clock edge): state goes to IDLE. freq_hz, freq_valid, overflow and gate all go to 0. Edge counter, gate counter, overflow flag and all synchronizer flops go to 0.
- Synchronizer:
  - sig_in passes through 2 flops (s1, s2), then a history flop s3.
  - rise = s2 & ~s3.
  - Detection latency is 2 cycles after sig_in is sampled high.
  - Because the flops reset to 0, a sig_in that is already high at reset release produces one rise. It is counted if a window is open.
- FSM states: IDLE, GATE, LATCH.
- IDLE:
  - gate=0.
  - If en=1, next state is GATE; the edge counter, gate counter and overflow flag clear to 0.
- GATE:
  - gate=1.
  - The gate counter increments every cycle, from 0 to GATE_CYCLES-1, so the window is exactly GATE_CYCLES cycles.
  - Each cycle with rise=1 increments the edge counter.
  - At 2^CNT_W-1 the edge counter saturates: it holds its value and the overflow flag sets (sticky for the window).
  - The cycle where the gate counter equals GATE_CYCLES-1 is still counted; next state is LATCH.
  - If en=0 in any GATE cycle: next state is IDLE and the window is discarded. There is no freq_valid pulse, freq_hz and overflow keep their previous values, and an edge in that cycle is not counted.
- LATCH (exactly 1 cycle):
  - gate=0; rises in this cycle are not counted (1-cycle dead time).
  - On the exit edge: freq_hz <= edge counter, overflow <= overflow flag, freq_valid=1 in the following cycle.
  - If en=1, next state is GATE with counters and flag cleared. Consecutive freq_valid pulses are therefore GATE_CYCLES+1 cycles apart.
  - If en=0, next state is IDLE; the result is still published.
- freq_valid is registered and high for exactly one cycle per completed window. freq_hz and overflow are stable between pulses.
- Gate counter width is clog2(GATE_CYCLES). Edge counter width is CNT_W, unsigned.
- Maximum measurable input is about 24 MHz (input toggling every cycle); higher input frequencies alias by design.
- Reset mid-window: the window is aborted and all outputs read 0 on the next cycle. A new window starts 1 cycle after rst_n returns high, if en=1.

Test Plan (GATE_CYCLES=100 unless noted):
1. Reset: hold rst_n=0 for 3 cycles with sig_in toggling -> freq_hz=0, freq_valid=0, overflow=0, gate=0 throughout.
2. en=1, sig_in period 10 cycles (50% duty) -> gate high for exactly 100 cycles. freq_valid pulses every 101 cycles with freq_hz=10 and overflow=0 on every window.
3. sig_in toggling every cycle (period 2) -> freq_hz=50. With CNT_W=4 instead -> freq_hz=15 and overflow=1. A following window at period 10 -> freq_hz=10 and overflow=0.
4. sig_in held constant 0, then constant 1 (held from before en rises) -> freq_hz=0 for every window, except 1 when the single synchronizer rise lands inside a window.
5. en dropped at gate cycle 50 -> gate=0 on the next cycle, no freq_valid, and freq_hz keeps its previous value (10). Re-assert en -> a new full 100-cycle window, then freq_hz=10.
6. rst_n pulsed low at gate cycle 30 -> all outputs 0 on the next cycle. After release with en=1, gate rises 1 cycle later and the first freq_valid arrives 101 cycles after that.
